// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 64;
  localparam int unsigned FETCH_INSTR_W = 32;

  typedef enum logic {
    FETCH     = 1'b0,
    MISS_WAIT = 1'b1
  } fetch_state_t;

  // Queue entry layout, most significant field first; the top packs entries
  // in this same order at its own parameter widths.
  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
    logic                     pred_taken;
    logic [FETCH_ADDR_W-1:0]  pred_target;
  } fetch_entry_t;

  function automatic int unsigned fetch_entry_width(input int unsigned addr_w,
                                                    input int unsigned instr_w);
    return instr_w + 2 * addr_w + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue with synchronous flush and separate occupancy counter.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = fetch_entry_width(FETCH_ADDR_W, FETCH_INSTR_W),
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       enq_i,
  input  logic [DATA_WIDTH-1:0]      enq_data_i,
  input  logic                       deq_i,
  output logic [DATA_WIDTH-1:0]      deq_data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;

  assign deq_data_o = mem_q[rd_ptr_q];
  assign valid_o    = (count_q != '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign count_o    = count_q;

  // Next pointer/occupancy; flush wins over any enq/deq in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq_i) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({enq_i, deq_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful where count marks them valid.
  always_ff @(posedge clk_i) begin
    if (enq_i && !flush_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC register, next-PC selection, I-miss FSM, fetch queue.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = FETCH_ADDR_W,
  parameter int unsigned           INSTR_WIDTH = FETCH_INSTR_W,
  parameter int unsigned           QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                         i_clk,
  input  logic                         i_arst,
  input  logic                         i_redirect,
  input  logic [ADDR_WIDTH-1:0]        i_redirect_pc,
  input  logic                         i_bp_taken,
  input  logic [ADDR_WIDTH-1:0]        i_bp_target,
  input  logic                         i_icache_hit,
  input  logic [INSTR_WIDTH-1:0]       i_icache_instr,
  input  logic                         i_refill_done,
  input  logic                         i_deq_ready,
  output logic [ADDR_WIDTH-1:0]        o_fetch_pc,
  output logic                         o_miss_req,
  output logic [ADDR_WIDTH-1:0]        o_miss_addr,
  output logic                         o_deq_valid,
  output logic [INSTR_WIDTH-1:0]       o_deq_instr,
  output logic [ADDR_WIDTH-1:0]        o_deq_pc,
  output logic [ADDR_WIDTH-1:0]        o_deq_pc_plus4,
  output logic                         o_deq_pred_taken,
  output logic [ADDR_WIDTH-1:0]        o_deq_pred_target,
  output logic [$clog2(QUEUE_DEPTH):0] o_count
);

  localparam int unsigned ENTRY_W = fetch_entry_width(ADDR_WIDTH, INSTR_WIDTH);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  miss_req_q, miss_req_d;
  logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;

  logic                  q_full;
  logic                  q_valid;
  logic                  enq;
  logic                  deq;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ENTRY_W-1:0]    enq_entry;
  logic [ENTRY_W-1:0]    head_entry;

  assign pc_plus4  = pc_q + ADDR_WIDTH'(4);
  assign enq       = (state_q == FETCH) && i_icache_hit && !q_full && !i_redirect;
  assign deq       = q_valid && i_deq_ready && !i_redirect;
  assign enq_entry = {i_icache_instr, pc_q, i_bp_taken, i_bp_target};

  fetch_fifo #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH      (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i      (i_clk),
    .rst_ni     (i_arst),
    .flush_i    (i_redirect),
    .enq_i      (enq),
    .enq_data_i (enq_entry),
    .deq_i      (deq),
    .deq_data_o (head_entry),
    .valid_o    (q_valid),
    .full_o     (q_full),
    .count_o    (o_count)
  );

  assign {o_deq_instr, o_deq_pc, o_deq_pred_taken, o_deq_pred_target} = head_entry;
  assign o_deq_pc_plus4 = o_deq_pc + ADDR_WIDTH'(4);
  assign o_deq_valid    = q_valid;
  assign o_fetch_pc     = pc_q;
  assign o_miss_req     = miss_req_q;
  assign o_miss_addr    = miss_addr_q;

  // Next PC and miss FSM; a redirect retargets the PC without aborting a refill.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    miss_req_d  = miss_req_q;
    miss_addr_d = miss_addr_q;
    if (i_redirect)  pc_d = i_redirect_pc;
    else if (enq)    pc_d = i_bp_taken ? i_bp_target : pc_plus4;
    unique case (state_q)
      FETCH: begin
        if (!i_redirect && !i_icache_hit && !q_full) begin
          state_d     = MISS_WAIT;
          miss_req_d  = 1'b1;
          miss_addr_d = pc_q;
        end
      end
      MISS_WAIT: begin
        if (i_refill_done) begin
          state_d    = FETCH;
          miss_req_d = 1'b0;
        end
      end
      default: begin
        state_d    = FETCH;
        miss_req_d = 1'b0;
      end
    endcase
  end

  // FSM, PC and registered miss outputs.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      miss_req_q  <= 1'b0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_req_q  <= miss_req_d;
      miss_addr_q <= miss_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_fetch_queue_unit;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        taken;
    logic [63:0] tgt;
  } ref_entry_t;

  logic        i_clk = 1'b0;
  logic        i_arst;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        i_bp_taken;
  logic [63:0] i_bp_target;
  logic        i_icache_hit;
  logic [31:0] i_icache_instr;
  logic        i_refill_done;
  logic        i_deq_ready;
  logic [63:0] o_fetch_pc;
  logic        o_miss_req;
  logic [63:0] o_miss_addr;
  logic        o_deq_valid;
  logic [31:0] o_deq_instr;
  logic [63:0] o_deq_pc;
  logic [63:0] o_deq_pc_plus4;
  logic        o_deq_pred_taken;
  logic [63:0] o_deq_pred_target;
  logic [2:0]  o_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  ref_entry_t  mq[$];
  logic [63:0] m_pc;
  bit          m_miss;
  logic [63:0] m_maddr;

  fetch_queue_unit #(
    .ADDR_WIDTH  (64),
    .INSTR_WIDTH (32),
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (64'h0)
  ) dut (
    .i_clk             (i_clk),
    .i_arst            (i_arst),
    .i_redirect        (i_redirect),
    .i_redirect_pc     (i_redirect_pc),
    .i_bp_taken        (i_bp_taken),
    .i_bp_target       (i_bp_target),
    .i_icache_hit      (i_icache_hit),
    .i_icache_instr    (i_icache_instr),
    .i_refill_done     (i_refill_done),
    .i_deq_ready       (i_deq_ready),
    .o_fetch_pc        (o_fetch_pc),
    .o_miss_req        (o_miss_req),
    .o_miss_addr       (o_miss_addr),
    .o_deq_valid       (o_deq_valid),
    .o_deq_instr       (o_deq_instr),
    .o_deq_pc          (o_deq_pc),
    .o_deq_pc_plus4    (o_deq_pc_plus4),
    .o_deq_pred_taken  (o_deq_pred_taken),
    .o_deq_pred_target (o_deq_pred_target),
    .o_count           (o_count)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ pc[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc    = 64'h0;
    m_miss  = 1'b0;
    m_maddr = 64'h0;
  endtask

  // One clock edge of the architectural rules, evaluated on current inputs.
  task automatic model_step();
    bit         full;
    bit         was_miss;
    ref_entry_t e;
    full     = (mq.size() == DEPTH);
    was_miss = m_miss;
    if (i_redirect) begin
      mq.delete();
      m_pc = i_redirect_pc;
      if (was_miss && i_refill_done) m_miss = 1'b0;
    end else begin
      if (mq.size() > 0 && i_deq_ready) void'(mq.pop_front());
      if (!was_miss) begin
        if (i_icache_hit && !full) begin
          e = '{instr: i_icache_instr, pc: m_pc, taken: i_bp_taken, tgt: i_bp_target};
          mq.push_back(e);
          m_pc = i_bp_taken ? i_bp_target : m_pc + 64'd4;
        end else if (!i_icache_hit && !full) begin
          m_miss  = 1'b1;
          m_maddr = m_pc;
        end
      end else if (i_refill_done) begin
        m_miss = 1'b0;
      end
    end
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic cycle();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
  endtask

  task automatic drive_icache(input bit hit);
    i_icache_hit   = hit;
    i_icache_instr = instr_of(o_fetch_pc);
  endtask

  task automatic idle_inputs();
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_bp_taken    = 1'b0;
    i_bp_target   = '0;
    i_icache_hit  = 1'b0;
    i_icache_instr = '0;
    i_refill_done = 1'b0;
    i_deq_ready   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_arst = 1'b0;
    repeat (2) @(negedge i_clk);
    model_reset();
    i_arst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_arst = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_fetch_pc !== 64'h0) begin n_err++; $display("FAIL reset_pc: got %h expected %h", o_fetch_pc, 64'h0); end
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    n_cmp++; if (o_deq_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_deq_valid); end
    n_cmp++; if (o_miss_req !== 1'b0) begin n_err++; $display("FAIL reset_miss_req: got %b expected 0", o_miss_req); end
    n_cmp++; if (o_miss_addr !== 64'h0) begin n_err++; $display("FAIL reset_miss_addr: got %h expected 0", o_miss_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    i_deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_icache(1'b1);
      cycle();
      n_cmp++; if (o_deq_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, o_deq_valid); end
      n_cmp++; if (o_deq_pc !== 64'(4 * i)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, o_deq_pc, 64'(4 * i)); end
      n_cmp++; if (o_deq_pc_plus4 !== 64'(4 * i + 4)) begin n_err++; $display("FAIL seq_pc4[%0d]: got %h expected %h", i, o_deq_pc_plus4, 64'(4 * i + 4)); end
      n_cmp++; if (o_deq_instr !== instr_of(64'(4 * i))) begin n_err++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, o_deq_instr, instr_of(64'(4 * i))); end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      drive_icache(1'b1);
      cycle();
      n_cmp++; if (o_count !== 3'((i < 4) ? i : 4)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, o_count, (i < 4) ? i : 4); end
    end
    n_cmp++; if (o_fetch_pc !== 64'h10) begin n_err++; $display("FAIL full_hold_pc: got %h expected 10", o_fetch_pc); end
    i_deq_ready = 1'b1;
    drive_icache(1'b1);
    cycle();
    n_cmp++; if (o_count !== 3'd3) begin n_err++; $display("FAIL drain1_count: got %0d expected 3", o_count); end
    n_cmp++; if (o_fetch_pc !== 64'h10) begin n_err++; $display("FAIL drain1_pc: got %h expected 10", o_fetch_pc); end
    n_cmp++; if (o_deq_pc !== 64'h4) begin n_err++; $display("FAIL drain1_head: got %h expected 4", o_deq_pc); end
    drive_icache(1'b1);
    cycle();
    n_cmp++; if (o_count !== 3'd3) begin n_err++; $display("FAIL drain2_count: got %0d expected 3", o_count); end
    n_cmp++; if (o_fetch_pc !== 64'h14) begin n_err++; $display("FAIL drain2_pc: got %h expected 14", o_fetch_pc); end
    n_cmp++; if (o_deq_pc !== 64'h8) begin n_err++; $display("FAIL drain2_head: got %h expected 8", o_deq_pc); end
  endtask

  task automatic test_predict();
    do_reset();
    i_deq_ready = 1'b1;
    i_bp_target = 64'h100;
    for (int i = 0; i < 3; i++) begin
      drive_icache(1'b1);
      i_bp_taken = (o_fetch_pc == 64'h8);
      cycle();
    end
    n_cmp++; if (o_fetch_pc !== 64'h100) begin n_err++; $display("FAIL pred_next_pc: got %h expected 100", o_fetch_pc); end
    n_cmp++; if (o_deq_pc !== 64'h8) begin n_err++; $display("FAIL pred_head_pc: got %h expected 8", o_deq_pc); end
    n_cmp++; if (o_deq_pred_taken !== 1'b1) begin n_err++; $display("FAIL pred_taken: got %b expected 1", o_deq_pred_taken); end
    n_cmp++; if (o_deq_pred_target !== 64'h100) begin n_err++; $display("FAIL pred_target: got %h expected 100", o_deq_pred_target); end
    drive_icache(1'b1);
    i_bp_taken = 1'b0;
    cycle();
    n_cmp++; if (o_deq_pc !== 64'h100) begin n_err++; $display("FAIL pred_follow_pc: got %h expected 100", o_deq_pc); end
    n_cmp++; if (o_deq_pred_taken !== 1'b0) begin n_err++; $display("FAIL pred_follow_taken: got %b expected 0", o_deq_pred_taken); end
  endtask

  task automatic test_miss();
    int unsigned n;
    do_reset();
    i_deq_ready = 1'b1;
    n = 0;
    while (o_fetch_pc != 64'h20 && n < 40) begin
      drive_icache(1'b1);
      cycle();
      n++;
    end
    n_cmp++; if (o_fetch_pc !== 64'h20) begin n_err++; $display("FAIL miss_reach_pc: got %h expected 20", o_fetch_pc); end
    drive_icache(1'b0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive_icache(1'b0);
      n_cmp++; if (o_miss_req !== 1'b1) begin n_err++; $display("FAIL miss_req[%0d]: got %b expected 1", i, o_miss_req); end
      n_cmp++; if (o_miss_addr !== 64'h20) begin n_err++; $display("FAIL miss_addr[%0d]: got %h expected 20", i, o_miss_addr); end
      n_cmp++; if (o_fetch_pc !== 64'h20) begin n_err++; $display("FAIL miss_pc[%0d]: got %h expected 20", i, o_fetch_pc); end
      cycle();
    end
    i_refill_done = 1'b1;
    drive_icache(1'b0);
    cycle();
    i_refill_done = 1'b0;
    n_cmp++; if (o_miss_req !== 1'b0) begin n_err++; $display("FAIL refill_miss_req: got %b expected 0", o_miss_req); end
    drive_icache(1'b1);
    cycle();
    n_cmp++; if (o_deq_valid !== 1'b1) begin n_err++; $display("FAIL refetch_valid: got %b expected 1", o_deq_valid); end
    n_cmp++; if (o_deq_pc !== 64'h20) begin n_err++; $display("FAIL refetch_pc: got %h expected 20", o_deq_pc); end
    n_cmp++; if (o_fetch_pc !== 64'h24) begin n_err++; $display("FAIL refetch_next_pc: got %h expected 24", o_fetch_pc); end
  endtask

  task automatic test_miss_redirect();
    int unsigned n;
    do_reset();
    n = 0;
    while (o_fetch_pc != 64'h20 && n < 40) begin
      i_deq_ready = (o_fetch_pc < 64'h18);
      drive_icache(1'b1);
      cycle();
      n++;
    end
    i_deq_ready = 1'b0;
    drive_icache(1'b0);
    cycle();
    n_cmp++; if (o_count === 3'd0) begin n_err++; $display("FAIL mr_pre_count: got %0d expected nonzero", o_count); end
    i_redirect    = 1'b1;
    i_redirect_pc = 64'h400;
    drive_icache(1'b0);
    cycle();
    i_redirect = 1'b0;
    n_cmp++; if (o_miss_req !== 1'b1) begin n_err++; $display("FAIL mr_miss_req: got %b expected 1", o_miss_req); end
    n_cmp++; if (o_miss_addr !== 64'h20) begin n_err++; $display("FAIL mr_miss_addr: got %h expected 20", o_miss_addr); end
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL mr_count: got %0d expected 0", o_count); end
    n_cmp++; if (o_deq_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid: got %b expected 0", o_deq_valid); end
    n_cmp++; if (o_fetch_pc !== 64'h400) begin n_err++; $display("FAIL mr_pc: got %h expected 400", o_fetch_pc); end
    for (int i = 0; i < 2; i++) begin
      drive_icache(1'b1);
      cycle();
      n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL mr_wait_count[%0d]: got %0d expected 0", i, o_count); end
    end
    i_refill_done = 1'b1;
    drive_icache(1'b1);
    cycle();
    i_refill_done = 1'b0;
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL mr_refill_count: got %0d expected 0", o_count); end
    drive_icache(1'b1);
    cycle();
    n_cmp++; if (o_deq_pc !== 64'h400) begin n_err++; $display("FAIL mr_first_pc: got %h expected 400", o_deq_pc); end
    n_cmp++; if (o_fetch_pc !== 64'h404) begin n_err++; $display("FAIL mr_next_pc: got %h expected 404", o_fetch_pc); end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_icache(1'b1);
      cycle();
    end
    n_cmp++; if (o_count !== 3'd3) begin n_err++; $display("FAIL rf_pre_count: got %0d expected 3", o_count); end
    i_redirect    = 1'b1;
    i_redirect_pc = 64'h800;
    i_deq_ready   = 1'b1;
    drive_icache(1'b1);
    cycle();
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL rf_count: got %0d expected 0", o_count); end
    n_cmp++; if (o_deq_valid !== 1'b0) begin n_err++; $display("FAIL rf_valid: got %b expected 0", o_deq_valid); end
    n_cmp++; if (o_fetch_pc !== 64'h800) begin n_err++; $display("FAIL rf_pc: got %h expected 800", o_fetch_pc); end
    i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    drive_icache(1'b1);
    cycle();
    i_redirect  = 1'b0;
    i_deq_ready = 1'b0;
    drive_icache(1'b1);
    cycle();
    n_cmp++; if (o_fetch_pc !== 64'h0) begin n_err++; $display("FAIL wrap_pc: got %h expected 0", o_fetch_pc); end
    n_cmp++; if (o_deq_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_head: got %h expected fffffffffffffffc", o_deq_pc); end
    n_cmp++; if (o_deq_pc_plus4 !== 64'h0) begin n_err++; $display("FAIL wrap_pc4: got %h expected 0", o_deq_pc_plus4); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_icache(1'b1);
      cycle();
    end
    drive_icache(1'b0);
    cycle();
    n_cmp++; if (o_miss_req !== 1'b1) begin n_err++; $display("FAIL ar_pre_miss: got %b expected 1", o_miss_req); end
    #2;
    i_arst = 1'b0;
    #1;
    n_cmp++; if (o_miss_req !== 1'b0) begin n_err++; $display("FAIL ar_miss_req: got %b expected 0", o_miss_req); end
    n_cmp++; if (o_fetch_pc !== 64'h0) begin n_err++; $display("FAIL ar_pc: got %h expected 0", o_fetch_pc); end
    n_cmp++; if (o_count !== 3'd0) begin n_err++; $display("FAIL ar_count: got %0d expected 0", o_count); end
    n_cmp++; if (o_miss_addr !== 64'h0) begin n_err++; $display("FAIL ar_miss_addr: got %h expected 0", o_miss_addr); end
    @(negedge i_clk);
    model_reset();
    i_arst = 1'b1;
  endtask

  task automatic test_random();
    ref_entry_t h;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      i_redirect    = ($urandom_range(15) == 0);
      i_redirect_pc = ($urandom_range(7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                               : {32'h0, $urandom} & ~64'h3;
      i_bp_taken    = ($urandom_range(3) == 0);
      i_bp_target   = {$urandom, $urandom} & ~64'h3;
      i_refill_done = ($urandom_range(5) == 0);
      i_deq_ready   = ($urandom_range(1) == 0);
      drive_icache($urandom_range(3) != 0);
      cycle();
      n_cmp++; if (o_fetch_pc !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, o_fetch_pc, m_pc); end
      n_cmp++; if (o_count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, o_count, mq.size()); end
      n_cmp++; if (o_deq_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, o_deq_valid, mq.size() != 0); end
      n_cmp++; if (o_miss_req !== m_miss) begin n_err++; $display("FAIL rnd_miss_req[%0d]: got %b expected %b", i, o_miss_req, m_miss); end
      n_cmp++; if (o_miss_addr !== m_maddr) begin n_err++; $display("FAIL rnd_miss_addr[%0d]: got %h expected %h", i, o_miss_addr, m_maddr); end
      if (mq.size() != 0) begin
        h = mq[0];
        n_cmp++; if (o_deq_pc !== h.pc) begin n_err++; $display("FAIL rnd_head_pc[%0d]: got %h expected %h", i, o_deq_pc, h.pc); end
        n_cmp++; if (o_deq_pc_plus4 !== h.pc + 64'd4) begin n_err++; $display("FAIL rnd_head_pc4[%0d]: got %h expected %h", i, o_deq_pc_plus4, h.pc + 64'd4); end
        n_cmp++; if (o_deq_instr !== h.instr) begin n_err++; $display("FAIL rnd_head_instr[%0d]: got %h expected %h", i, o_deq_instr, h.instr); end
        n_cmp++; if (o_deq_pred_taken !== h.taken) begin n_err++; $display("FAIL rnd_head_taken[%0d]: got %b expected %b", i, o_deq_pred_taken, h.taken); end
        n_cmp++; if (o_deq_pred_target !== h.tgt) begin n_err++; $display("FAIL rnd_head_tgt[%0d]: got %h expected %h", i, o_deq_pred_target, h.tgt); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    i_arst = 1'b0;
    @(negedge i_clk);
    test_reset();
    test_sequential();
    test_full();
    test_predict();
    test_miss();
    test_miss_redirect();
    test_redirect_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised next-generation fetch front end. Owns the PC register, next-PC selection (redirect / predicted target / PC+4) and an instruction-miss handshake FSM. Adds a QUEUE_DEPTH-entry fetch queue that decouples fetch from decode, so decode stalls no longer freeze the PC. The I-cache and branch predictor stay external and are looked up combinationally on o_fetch_pc.

Parameters:
ADDR_WIDTH, 64, PC/address width.
INSTR_WIDTH, 32, instruction width.
QUEUE_DEPTH, 4, fetch queue entries; power of two, >= 2.
RESET_PC, 0, PC value loaded on reset.

Ports:
i_clk  in  1  clock, all state updates on rising edge.
i_arst  in  1  asynchronous, active-low reset.
i_redirect  in  1  exec mispredict/redirect; flushes the queue.
i_redirect_pc  in  ADDR_WIDTH  redirect target.
i_bp_taken  in  1  predictor says taken for o_fetch_pc.
i_bp_target  in  ADDR_WIDTH  predicted target for o_fetch_pc.
i_icache_hit  in  1  I-cache hit for o_fetch_pc.
i_icache_instr  in  INSTR_WIDTH  instruction at o_fetch_pc, valid when hit.
i_refill_done  in  1  one-cycle pulse: refill for o_miss_addr has been written to the I-cache.
i_deq_ready  in  1  decode accepts the head entry.
o_fetch_pc  out  ADDR_WIDTH  current PC, driven to I-cache and predictor.
o_miss_req  out  1  refill request, level.
o_miss_addr  out  ADDR_WIDTH  latched miss address.
o_deq_valid  out  1  queue non-empty.
o_deq_instr  out  INSTR_WIDTH  head instruction.
o_deq_pc  out  ADDR_WIDTH  head PC.
o_deq_pc_plus4  out  ADDR_WIDTH  head PC + 4.
o_deq_pred_taken  out  1  head prediction.
o_deq_pred_target  out  ADDR_WIDTH  head predicted target.
o_count  out  $clog2(QUEUE_DEPTH)+1  queue occupancy.

Behaviour:
- Reset (i_arst low, asynchronous): PC = RESET_PC, state = FETCH, queue empty, o_count = 0, o_deq_valid = 0, o_miss_req = 0, o_miss_addr = 0.
- FSM has two states, FETCH and MISS_WAIT.
- Definitions used below:
  - full = (o_count == QUEUE_DEPTH).
  - enq = FETCH & hit & ~full & ~i_redirect.
  - deq = o_deq_valid & i_deq_ready & ~i_redirect.
- Enqueue: on enq, write {i_icache_instr, PC, i_bp_taken, i_bp_target}. Next PC = i_bp_taken ? i_bp_target : PC+4.
- Hold conditions: PC is held when not enq and not redirect. Full blocks enqueue even if a dequeue fires in the same cycle; there is no ready-to-enqueue combinational path.
- Miss detection: in FETCH, ~hit & ~full & ~i_redirect moves to MISS_WAIT. That edge sets o_miss_req = 1 and o_miss_addr = PC.
- MISS_WAIT: o_miss_req held high and o_miss_addr stable until i_refill_done.
  - On i_refill_done, the next cycle is FETCH with o_miss_req = 0.
  - The refetch of PC then hits.
  - i_refill_done outside MISS_WAIT is ignored.
- Redirect (any state):
  - PC <= i_redirect_pc.
  - Queue cleared (count 0, pointers 0) next cycle.
  - No enqueue or dequeue that cycle.
  - In MISS_WAIT the refill is not aborted: stay in MISS_WAIT, keep o_miss_addr, resume FETCH at the redirected PC after i_refill_done.
  - Redirect and i_refill_done in the same cycle: PC = redirect target, state = FETCH.
- Simultaneous enq and deq: count unchanged, both pointers advance.
- Pointers wrap modulo QUEUE_DEPTH. Occupancy is kept in a separate counter.
- Arithmetic: PC+4 wraps modulo 2^ADDR_WIDTH (0xFFFF_FFFF_FFFF_FFFC + 4 = 0).
- Latency:
  - A hit enters the queue at the clock edge.
  - The entry is visible on o_deq_* the next cycle.
  - Queue outputs come straight from storage; no combinational path from fetch inputs.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {FETCH, MISS_WAIT}.
  - fetch_entry_t struct {instr, pc, pred_taken, pred_target}, parametrised by ADDR_WIDTH/INSTR_WIDTH via package localparams.
- Sub-module fetch_fifo holds the circular buffer with synchronous flush, enq/deq, count, and full/empty.
- The top level holds the PC register, next-PC mux and FSM.

Test Plan:
- Reset then release, hit always, no prediction, i_deq_ready = 1 -> o_deq_pc sequence 0x0, 0x4, 0x8 on consecutive cycles. o_deq_pc_plus4 = o_deq_pc + 4.
- i_deq_ready = 0, hit always, QUEUE_DEPTH = 4 -> o_count reaches 4, o_fetch_pc holds at 0x10. Asserting ready with hit still high drains one per cycle; PC resumes 0x14 the cycle after count drops to 3.
- At PC 0x8, i_bp_taken = 1 with target 0x100 -> entry 0x8 has pred_taken = 1. Next fetched PC is 0x100.
- Miss at 0x20 -> o_miss_req = 1, o_miss_addr = 0x20, held 5 cycles. i_refill_done pulse -> FETCH, 0x20 enqueued on the hit.
- In MISS_WAIT for 0x20, redirect to 0x400 -> o_miss_addr stays 0x20, queue empties. After i_refill_done, first enqueued PC is 0x400.
- Queue holding 3 entries with simultaneous i_redirect, i_deq_ready = 1 and hit -> next cycle o_count = 0, o_deq_valid = 0, o_fetch_pc = i_redirect_pc. Also: async reset asserted mid-MISS_WAIT -> o_miss_req = 0 immediately, PC = RESET_PC.
